rdclk_port_arbiter: RTL and testbench
=====================================

Name: rdclk_port_arbiter

Overview:
- Round-robin arbiter that shares one read-clocked 1-bit lookup primitive among N_REQ requesters.
- The primitive has clock port `rdclk`, input `a` and output `o`.
- The arbiter drives the primitive's `a`, waits a fixed read latency, samples `o`, and returns the result to the winning requester.
- It sits between requester logic and the primitive instance in the clock test fabric, and uses `rdclk` as its only clock so that clock detection tools infer it as a clock net.

Parameters:
- N_REQ, 4, number of requesters. Must be >= 1.
- LATENCY, 1, `rdclk` cycles from `blk_a` stable to `blk_o` valid. Must be >= 1.
- CNT_W, $clog2(LATENCY+1), width of the latency counter. Derived; not overridden.

Ports:
- rdclk  input  1  Sole clock; all state updates on rising edge.
- rst  input  1  Asynchronous reset, active-high.
- req_valid  input  N_REQ  Per-requester request valid.
- req_a  input  N_REQ  Per-requester data bit to drive onto the primitive `a`.
- req_ready  output  N_REQ  One-hot accept; at most one bit high.
- rsp_valid  output  N_REQ  One-hot, single-cycle response strobe to the granted requester.
- rsp_o  output  1  Sampled primitive output; meaningful only when rsp_valid != 0.
- blk_a  output  1  Registered drive to primitive input `a`.
- blk_o  input  1  Primitive output `o`.
- busy  output  1  High whenever state != IDLE.

Behaviour:
- **Reset (async, immediate):**
  - state=IDLE, ptr=0, gnt=0, cnt=0.
  - blk_a=0, rsp_o=0, rsp_valid=0, busy=0.
  - req_ready=0 while rst is high.
  - Reset mid-transaction drops that transaction: no rsp_valid is ever issued for it.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - Winner g is the first index with req_valid high, searching ptr, ptr+1, … mod N_REQ.
  - req_ready[g] is combinational, asserted the same cycle; all other ready bits are 0.
  - If no req_valid bit is high: req_ready=0 and the FSM stays in IDLE.
  - On the edge with an accepted request: blk_a<=req_a[g], gnt<=g, cnt<=LATENCY, state<=WAIT.
- **WAIT:**
  - req_ready=0 and blk_a holds.
  - Each edge: cnt<=cnt-1.
  - On the edge where cnt==1: rsp_o<=blk_o, rsp_valid<=one-hot(gnt), state<=RESP.
- **RESP:**
  - rsp_valid is high for exactly this one cycle and rsp_o holds.
  - On the next edge: rsp_valid<=0, ptr<=(gnt+1) mod N_REQ, state<=IDLE.
  - rsp_o retains its value until the next response.
- **Timing:**
  - Accept in cycle T; rsp_valid visible in cycle T+LATENCY+1.
  - Earliest next accept is cycle T+LATENCY+2.
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- **Handshake rules:**
  - A requester may drop req_valid before being granted; nothing happens.
  - Keeping req_valid high after acceptance is treated as a new request in the next IDLE.
  - req_a is sampled only on the accept edge.
- **Fairness:**
  - ptr moves past the last winner only, so every continuously-valid requester is served within N_REQ transactions.
  - ptr wraps from N_REQ-1 to 0.
- **N_REQ=1:** ptr stays 0, and req_ready[0]=req_valid[0] in IDLE.
- **Outputs:** blk_a, rsp_o and rsp_valid are registered; only req_ready is combinational; busy decodes state.

Test Plan:
1. **Reset value check.** N_REQ=4, LATENCY=1. Assert rst mid-cycle with no clock edge → all outputs 0 immediately. Release rst → busy=0.
2. **Single request.** req_valid=4'b0100, req_a[2]=1 at T. Primitive model returns o=~a after 1 cycle.
   - req_ready=4'b0100 at T; blk_a=1 at T+1.
   - rsp_valid=4'b0100 and rsp_o=0 at T+2 only.
   - busy is high T+1..T+2.
3. **Round-robin.** req_valid=4'b1111 held constant.
   - Grants occur in order 0,1,2,3,0, every 3 cycles.
   - No grant goes to the same index twice within 4 transactions.
4. **Latency parameter.** LATENCY=3, single request at T → rsp_valid at T+4 exactly, and blk_a is stable T+1..T+4.
5. **Reset mid-operation.** Accept at T; assert rst at T+1 (in WAIT).
   - No rsp_valid appears at any later cycle; ptr=0.
   - After release, a fresh request from index 3 is granted normally.
6. **Withdraw and wrap.** Requester 1 pulses req_valid only while busy=1 → no grant occurs to it. Then with ptr=3, req_valid=4'b1001 → index 3 is granted first, then index 0.

Source files
------------

// File: rtl/rdclk_port_arbiter.sv
// -----------------------------------------------------------------------------
// rdclk_port_arbiter
//
// Round-robin arbiter sharing one read-clocked 1-bit lookup primitive among
// N_REQ requesters. The winner's data bit is registered onto the primitive
// input (blk_a). The primitive output (blk_o) is sampled LATENCY rdclk cycles
// later and returned as a single-cycle one-hot strobe to the winner.
// rdclk is the only clock, so clock-detection tools see it as a clock net.
//
// Ports:
//   rdclk      in   1      sole clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   req_valid  in   N_REQ  per-requester request valid
//   req_a      in   N_REQ  per-requester bit to drive onto the primitive
//   req_ready  out  N_REQ  one-hot accept (combinational, IDLE only)
//   rsp_valid  out  N_REQ  one-hot single-cycle response strobe
//   rsp_o      out  1      sampled primitive output
//   blk_a      out  1      registered drive to primitive input a
//   blk_o      in   1      primitive output o
//   busy       out  1      high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module rdclk_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 1,
    parameter int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic             rdclk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_a,
    output logic [N_REQ-1:0] req_ready,
    output logic [N_REQ-1:0] rsp_valid,
    output logic             rsp_o,
    output logic             blk_a,
    input  logic             blk_o,
    output logic             busy
);

    // A one-bit pointer is kept even when N_REQ==1 so every vector is legal.
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]   N_REQ_EXT = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               blk_a_q, blk_a_d;
    logic               rsp_o_q, rsp_o_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    // -------------------------------------------------------------------------
    // Round-robin winner search
    // -------------------------------------------------------------------------
    // Rotating the request vector right by ptr puts requester ptr at bit 0, so
    // the lowest set bit of the rotated vector is the offset of the winner.
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [PTR_W-1:0]   win_off;
    logic [PTR_W:0]     win_sum;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_dbl   = {req_valid, req_valid} >> ptr_q;
        req_rot   = req_dbl[N_REQ-1:0];
        win_found = |req_rot;
        win_off   = '0;
        // Descending scan: the lowest set offset is the last one written.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_off = PTR_W'(j);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= N_REQ_EXT) begin
            win_sum = win_sum - N_REQ_EXT;
        end
        win_idx = win_sum[PTR_W-1:0];
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (win_found)                state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == CNT_W'(1))       state_d = ST_RESP;
            ST_RESP:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != ST_IDLE);
        req_ready = '0;
        // Gated with rst so no requester sees an accept that the reset discards.
        if ((state_q == ST_IDLE) && win_found && !rst) begin
            req_ready = N_REQ'(1) << win_idx;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        blk_a_d     = blk_a_q;
        rsp_o_d     = rsp_o_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    blk_a_d = req_a[win_idx];
                    gnt_d   = win_idx;
                    cnt_d   = CNT_W'(LATENCY);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_o_d     = blk_o;
                    rsp_valid_d = N_REQ'(1) << gnt_q;
                end
            end
            ST_RESP: begin
                rsp_valid_d = '0;
                // Advance only past the last winner; this is what makes the
                // rotation fair for continuously-valid requesters.
                ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + PTR_W'(1);
            end
            default: begin
                rsp_valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            blk_a_q     <= 1'b0;
            rsp_o_q     <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            blk_a_q     <= blk_a_d;
            rsp_o_q     <= rsp_o_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign blk_a     = blk_a_q;
    assign rsp_o     = rsp_o_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_rdclk_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rdclk_port_arbiter
//
// Directed bench for rdclk_port_arbiter. Two instances share clock and reset:
// dut (N_REQ=4, LATENCY=1) and dut3 (N_REQ=4, LATENCY=3). Each primitive is
// modelled as o = ~a, settling well within a cycle. Inputs are driven just
// after the falling edge; registered outputs are checked at the falling edge
// and combinational req_ready 1 time unit after inputs change.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rdclk_port_arbiter;

    logic       rdclk = 1'b0;
    logic       rst;
    logic [3:0] req_valid, req_a, req_ready, rsp_valid;
    logic       rsp_o, blk_a, blk_o, busy;
    logic [3:0] req_valid3, req_a3, req_ready3, rsp_valid3;
    logic       rsp_o3, blk_a3, blk_o3, busy3;

    int errors = 0;
    int checks = 0;

    assign blk_o  = ~blk_a;
    assign blk_o3 = ~blk_a3;

    always #5 rdclk = ~rdclk;

    rdclk_port_arbiter #(.N_REQ(4), .LATENCY(1)) dut (
        .rdclk(rdclk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_o(rsp_o),
        .blk_a(blk_a), .blk_o(blk_o), .busy(busy)
    );

    rdclk_port_arbiter #(.N_REQ(4), .LATENCY(3)) dut3 (
        .rdclk(rdclk), .rst(rst), .req_valid(req_valid3), .req_a(req_a3),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_o(rsp_o3),
        .blk_a(blk_a3), .blk_o(blk_o3), .busy(busy3)
    );

    task automatic tick();
        @(negedge rdclk);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        tick();
        req_valid = 4'b0001; req_a = 4'b0001;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
        checks++; if (blk_a !== 1'b1) begin errors++; $display("FAIL reset_pre_blk_a: got %b want 1", blk_a); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (blk_a !== 1'b0) begin errors++; $display("FAIL reset_blk_a: got %b want 0", blk_a); end
        checks++; if (rsp_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_o: got %b want 0", rsp_o); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        tick();
        req_valid = 4'b0000; req_a = 4'b0000; rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_release_ready: got %b want 0000", req_ready); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single();
        tick();
        req_valid = 4'b0100; req_a = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_T: got %b want 0", busy); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_T1: got %b want 1", busy); end
        checks++; if (blk_a !== 1'b1) begin errors++; $display("FAIL single_blk_a: got %b want 1", blk_a); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_early: got %b want 0000", rsp_valid); end
        req_valid = 4'b0000; req_a = 4'b0000;
        tick();
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
        checks++; if (rsp_o !== 1'b0) begin errors++; $display("FAIL single_rsp_o: got %b want 0", rsp_o); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_T2: got %b want 1", busy); end
        tick();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_late: got %b want 0000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_T3: got %b want 0", busy); end
    endtask

    // -------------------------------------------------------------------------
    // Pointer sits at 3 on entry (last winner was 2).
    task automatic test_withdraw_wrap();
        tick();
        req_valid = 4'b0100; req_a = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wd_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0010;   // requester 1 pulses only while busy
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_ready_wait: got %b want 0000", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_ready_resp: got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL wd_rsp_valid: got %b want 0100", rsp_valid); end
        checks++; if (rsp_o !== 1'b1) begin errors++; $display("FAIL wd_rsp_o: got %b want 1", rsp_o); end
        tick();
        req_valid = 4'b0000;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_no_grant: busy %b want 0", busy); end
        // Wrap: ptr=3 with requesters 3 and 0 valid.
        req_valid = 4'b1001; req_a = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3: got %b want 1000", req_ready); end
        tick();
        checks++; if (blk_a !== 1'b1) begin errors++; $display("FAIL wrap_blk_a3: got %b want 1", blk_a); end
        tick();
        checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL wrap_rsp3: got %b want 1000", rsp_valid); end
        checks++; if (rsp_o !== 1'b0) begin errors++; $display("FAIL wrap_rsp_o3: got %b want 0", rsp_o); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready0: got %b want 0001", req_ready); end
        tick();
        tick();
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL wrap_rsp0: got %b want 0001", rsp_valid); end
        checks++; if (rsp_o !== 1'b0) begin errors++; $display("FAIL wrap_rsp_o0: got %b want 0", rsp_o); end
        req_valid = 4'b0000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle: busy %b want 0", busy); end
    endtask

    // -------------------------------------------------------------------------
    // Pointer sits at 1 on entry.
    task automatic test_reset_mid();
        tick();
        req_valid = 4'b0010; req_a = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_ready: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0000; req_a = 4'b0000;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_rst: got %b want 0", busy); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_no_rsp[%0d]: got %b want 0000", i, rsp_valid); end
            tick();
        end
        // All valid: the winner exposes the pointer, which must be back at 0.
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ptr0: got %b want 0001", req_ready); end
        req_valid = 4'b1000; req_a = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rmid_ready3: got %b want 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (blk_a !== 1'b0) begin errors++; $display("FAIL rmid_blk_a: got %b want 0", blk_a); end
        tick();
        checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL rmid_rsp3: got %b want 1000", rsp_valid); end
        checks++; if (rsp_o !== 1'b1) begin errors++; $display("FAIL rmid_rsp_o: got %b want 1", rsp_o); end
        tick();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_rsp_clear: got %b want 0000", rsp_valid); end
    endtask

    // -------------------------------------------------------------------------
    // Pointer sits at 0 on entry; all four requesters stay valid.
    task automatic test_round_robin();
        logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic       exp_o   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tick();
        req_valid = 4'b1111; req_a = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== exp_gnt[k]) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_gnt[k]); end
            tick();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_ready_busy[%0d]: got %b want 0000", k, req_ready); end
            tick();
            checks++; if (rsp_valid !== exp_gnt[k]) begin errors++; $display("FAIL rr_rsp[%0d]: got %b want %b", k, rsp_valid, exp_gnt[k]); end
            checks++; if (rsp_o !== exp_o[k]) begin errors++; $display("FAIL rr_rsp_o[%0d]: got %b want %b", k, rsp_o, exp_o[k]); end
            tick();
        end
        req_valid = 4'b0000; req_a = 4'b0000;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_latency();
        tick();
        req_valid3 = 4'b0010; req_a3 = 4'b0010;
        #1;
        checks++; if (req_ready3 !== 4'b0010) begin errors++; $display("FAIL lat_ready: got %b want 0010", req_ready3); end
        tick();
        checks++; if (blk_a3 !== 1'b1) begin errors++; $display("FAIL lat_blk_a_T1: got %b want 1", blk_a3); end
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b want 1", busy3); end
        checks++; if (rsp_valid3 !== 4'b0000) begin errors++; $display("FAIL lat_rsp_T1: got %b want 0000", rsp_valid3); end
        // req_a only matters on the accept edge.
        req_valid3 = 4'b0000; req_a3 = 4'b0000;
        for (int i = 2; i <= 3; i++) begin
            tick();
            checks++; if (blk_a3 !== 1'b1) begin errors++; $display("FAIL lat_blk_a_T%0d: got %b want 1", i, blk_a3); end
            checks++; if (rsp_valid3 !== 4'b0000) begin errors++; $display("FAIL lat_rsp_T%0d: got %b want 0000", i, rsp_valid3); end
        end
        tick();
        checks++; if (rsp_valid3 !== 4'b0010) begin errors++; $display("FAIL lat_rsp_T4: got %b want 0010", rsp_valid3); end
        checks++; if (rsp_o3 !== 1'b0) begin errors++; $display("FAIL lat_rsp_o: got %b want 0", rsp_o3); end
        checks++; if (blk_a3 !== 1'b1) begin errors++; $display("FAIL lat_blk_a_T4: got %b want 1", blk_a3); end
        tick();
        checks++; if (rsp_valid3 !== 4'b0000) begin errors++; $display("FAIL lat_rsp_T5: got %b want 0000", rsp_valid3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat_idle: got %b want 0", busy3); end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_valid3 = '0; req_a3 = '0;
        repeat (2) tick();
        rst = 1'b0;
        test_reset();
        test_single();
        test_withdraw_wrap();
        test_reset_mid();
        test_round_robin();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
